// File: rtl/kid_ctrl_pkg.sv
// Shared game-flow definitions: state encoding, default spawn point and the
// offset from the kid's centre to its sprite top-left corner.
package kid_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    localparam logic [9:0] SPAWN_X0_DEF = 10'd32;
    localparam logic [9:0] SPAWN_Y0_DEF = 10'd400;

    localparam logic [9:0] KID_OFF_X = 10'd15;
    localparam logic [9:0] KID_OFF_Y = 10'd11;

endpackage

// File: rtl/kid_ctrl_edge_det.sv
// Registered rising-edge detector; the previous value resets high so a level
// already asserted when reset releases is not seen as an edge.
module kid_ctrl_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/kid_ctrl.sv
// Game-flow controller: spawn/play/dying/dead sequencing, save point ownership,
// and derivation of the per-frame physics and animation enables.
module kid_ctrl
    import kid_ctrl_pkg::*;
#(
    parameter int         ANIM_DIV     = 6,
    parameter int         DEATH_FRAMES = 30,
    parameter int         SPAWN_FRAMES = 2,
    parameter logic [9:0] SPAWN_X0     = SPAWN_X0_DEF,
    parameter logic [9:0] SPAWN_Y0     = SPAWN_Y0_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_retry,
    input  logic       hit,
    input  logic       save_hit,
    input  logic [9:0] kid_x,
    input  logic [9:0] kid_y,
    output logic       kid_rst_n,
    output logic [9:0] spawn_x,
    output logic [9:0] spawn_y,
    output logic       update_en,
    output logic       toggle_en,
    output logic       game_over,
    output logic [7:0] death_cnt,
    output logic [1:0] state
);

    localparam int FRAME_MAX = (DEATH_FRAMES > SPAWN_FRAMES) ? DEATH_FRAMES : SPAWN_FRAMES;
    localparam int FCNT_W    = $clog2(FRAME_MAX + 1);
    localparam int ACNT_W    = $clog2(ANIM_DIV + 1);

    localparam logic [FCNT_W-1:0] SPAWN_LAST = FCNT_W'(SPAWN_FRAMES - 1);
    localparam logic [FCNT_W-1:0] DEATH_LAST = FCNT_W'(DEATH_FRAMES - 1);
    localparam logic [ACNT_W-1:0] ANIM_LAST  = ACNT_W'(ANIM_DIV - 1);

    state_t             r_state, w_state_nxt;
    logic [FCNT_W-1:0]  r_frame_cnt, w_frame_nxt;
    logic [ACNT_W-1:0]  r_anim_cnt, w_anim_nxt;
    logic [7:0]         r_death_cnt, w_death_nxt;
    logic [9:0]         r_spawn_x, w_spawn_x_nxt;
    logic [9:0]         r_spawn_y, w_spawn_y_nxt;
    logic               r_kid_rst_n, r_update_en, r_toggle_en, r_game_over;
    logic               w_update_nxt, w_toggle_nxt;
    logic               w_retry_rise, w_save_rise;

    kid_ctrl_edge_det u_retry_edge (
        .clk    (clk),
        .rst    (rst),
        .i_d    (key_retry),
        .o_rise (w_retry_rise)
    );

    kid_ctrl_edge_det u_save_edge (
        .clk    (clk),
        .rst    (rst),
        .i_d    (save_hit),
        .o_rise (w_save_rise)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame_cnt;
        w_anim_nxt    = r_anim_cnt;
        w_death_nxt   = r_death_cnt;
        w_spawn_x_nxt = r_spawn_x;
        w_spawn_y_nxt = r_spawn_y;
        w_update_nxt  = 1'b0;
        w_toggle_nxt  = 1'b0;

        case (r_state)
            ST_SPAWN: begin
                if (frame_tick) begin
                    if (r_frame_cnt == SPAWN_LAST) begin
                        w_state_nxt = ST_PLAY;
                        w_frame_nxt = '0;
                    end else begin
                        w_frame_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // hit beats retry beats save; leaving PLAY swallows this frame's step
                if (hit) begin
                    w_state_nxt = ST_DYING;
                    w_frame_nxt = '0;
                    if (r_death_cnt != 8'hFF) begin
                        w_death_nxt = r_death_cnt + 1'b1;
                    end
                end else if (w_retry_rise) begin
                    w_state_nxt = ST_SPAWN;
                    w_frame_nxt = '0;
                    w_anim_nxt  = '0;
                end else begin
                    if (w_save_rise) begin
                        w_spawn_x_nxt = kid_x - KID_OFF_X;
                        w_spawn_y_nxt = kid_y - KID_OFF_Y;
                    end
                    if (frame_tick) begin
                        w_update_nxt = 1'b1;
                        if (r_anim_cnt == ANIM_LAST) begin
                            w_anim_nxt   = '0;
                            w_toggle_nxt = 1'b1;
                        end else begin
                            w_anim_nxt = r_anim_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (r_frame_cnt == DEATH_LAST) begin
                        w_state_nxt = ST_DEAD;
                        w_frame_nxt = '0;
                    end else begin
                        w_frame_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                if (w_retry_rise) begin
                    w_state_nxt = ST_SPAWN;
                    w_frame_nxt = '0;
                    w_anim_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SPAWN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_SPAWN;
            r_frame_cnt <= '0;
            r_anim_cnt  <= '0;
            r_death_cnt <= 8'd0;
            r_spawn_x   <= SPAWN_X0;
            r_spawn_y   <= SPAWN_Y0;
            r_kid_rst_n <= 1'b0;
            r_update_en <= 1'b0;
            r_toggle_en <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_anim_cnt  <= w_anim_nxt;
            r_death_cnt <= w_death_nxt;
            r_spawn_x   <= w_spawn_x_nxt;
            r_spawn_y   <= w_spawn_y_nxt;
            // kid hold and game-over follow the next state so they move with state
            r_kid_rst_n <= (w_state_nxt != ST_SPAWN);
            r_update_en <= w_update_nxt;
            r_toggle_en <= w_toggle_nxt;
            r_game_over <= (w_state_nxt == ST_DEAD);
        end
    end

    assign kid_rst_n = r_kid_rst_n;
    assign spawn_x   = r_spawn_x;
    assign spawn_y   = r_spawn_y;
    assign update_en = r_update_en;
    assign toggle_en = r_toggle_en;
    assign game_over = r_game_over;
    assign death_cnt = r_death_cnt;
    assign state     = r_state;

endmodule
